// File: rtl/ai_core_pkg.sv
// Shared types and elaboration helpers for the dot-product datapath.
// Holds the accumulator FSM encoding and the width legality check.
package ai_core_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_e;

  // The accumulator must be at least as wide as a resolved beat.
  function automatic bit widths_ok(input int in_width, input int acc_width);
    return acc_width >= in_width;
  endfunction

endpackage

// File: rtl/carry_propagate_adder.sv
// Plain ripple/CPA adder: sum = a + b with the carry out of the top bit.
module carry_propagate_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/sign_extender.sv
// Widens a value to OUT_WIDTH, replicating the MSB when is_signed is set.
module sign_extender #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 16
) (
  input  logic [IN_WIDTH-1:0]  din,
  input  logic                 is_signed,
  output logic [OUT_WIDTH-1:0] dout
);

  logic ext_bit;

  assign ext_bit = is_signed & din[IN_WIDTH-1];

  // Fill with the extension bit first so OUT_WIDTH == IN_WIDTH needs no special case.
  always_comb begin
    dout                 = {OUT_WIDTH{ext_bit}};
    dout[IN_WIDTH-1:0]   = din;
  end

endmodule

// File: rtl/csa_accumulator.sv
// Resolves redundant sum/carry beats, accumulates them per group delimited by
// in_last, and emits one registered total per group through a valid/ready port.
module csa_accumulator
  import ai_core_pkg::*;
#(
  parameter int IN_WIDTH  = 14,
  parameter int ACC_WIDTH = 32,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_sum,
  input  logic [IN_WIDTH-1:0]  in_carry,
  input  logic                 in_last,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_overflow,
  output logic [CNT_WIDTH-1:0] out_count
);

  if (!widths_ok(IN_WIDTH, ACC_WIDTH)) begin : g_width_error
    $error("csa_accumulator: ACC_WIDTH must be >= IN_WIDTH");
  end

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high. valid never waits on ready; once raised, valid and its payload hold
  // until the transfer. The whole pipeline moves as one: when a result is
  // pending and not taken, in_ready drops and every stage freezes.
  logic advance;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // ---------------- Stage 1: carry-propagate resolve and extend ----------------
  logic [IN_WIDTH-1:0]  in_resolved;
  logic                 in_cout_unused;
  logic [ACC_WIDTH-1:0] in_ext;

  carry_propagate_adder #(.WIDTH(IN_WIDTH)) u_cpa_in (
    .a    (in_sum),
    .b    (in_carry),
    .sum  (in_resolved),
    .cout (in_cout_unused)
  );

  sign_extender #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(ACC_WIDTH)) u_ext (
    .din       (in_resolved),
    .is_signed (is_signed),
    .dout      (in_ext)
  );

  logic                 s1_valid;
  logic [ACC_WIDTH-1:0] s1_v;
  logic                 s1_last;
  logic                 s1_signed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_v      <= '0;
      s1_last   <= 1'b0;
      s1_signed <= 1'b0;
    end else if (advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_v      <= in_ext;
        s1_last   <= in_last;
        s1_signed <= is_signed;
      end
    end
  end

  // ---------------- Stage 2: group accumulator FSM ----------------
  acc_state_e           state, state_d;
  logic [ACC_WIDTH-1:0] acc, acc_d;
  logic [CNT_WIDTH-1:0] cnt, cnt_d;
  logic                 sticky, sticky_d;
  logic                 group_signed, group_signed_d;

  logic                 s2_valid, s2_valid_d;
  logic [ACC_WIDTH-1:0] s2_data, s2_data_d;
  logic                 s2_ovf, s2_ovf_d;
  logic [CNT_WIDTH-1:0] s2_cnt, s2_cnt_d;

  logic [ACC_WIDTH-1:0] acc_sum;
  logic                 acc_cout;
  logic                 beat_ovf;
  logic [CNT_WIDTH-1:0] cnt_inc;

  carry_propagate_adder #(.WIDTH(ACC_WIDTH)) u_cpa_acc (
    .a    (acc),
    .b    (s1_v),
    .sum  (acc_sum),
    .cout (acc_cout)
  );

  // Overflow follows the mode latched at the start of the group, not the beat's own flag.
  assign beat_ovf = group_signed
                  ? ((acc[ACC_WIDTH-1] == s1_v[ACC_WIDTH-1]) &&
                     (acc_sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]))
                  : acc_cout;

  assign cnt_inc = (cnt == {CNT_WIDTH{1'b1}}) ? cnt : cnt + CNT_ONE;

  always_comb begin
    state_d        = state;
    acc_d          = acc;
    cnt_d          = cnt;
    sticky_d       = sticky;
    group_signed_d = group_signed;
    s2_valid_d     = 1'b0;
    s2_data_d      = s2_data;
    s2_ovf_d       = s2_ovf;
    s2_cnt_d       = s2_cnt;
    if (s1_valid) begin
      case (state)
        IDLE: begin
          if (s1_last) begin
            s2_valid_d = 1'b1;
            s2_data_d  = s1_v;
            s2_ovf_d   = 1'b0;
            s2_cnt_d   = CNT_ONE;
          end else begin
            acc_d          = s1_v;
            cnt_d          = CNT_ONE;
            sticky_d       = 1'b0;
            group_signed_d = s1_signed;
            state_d        = ACCUM;
          end
        end
        ACCUM: begin
          if (s1_last) begin
            s2_valid_d = 1'b1;
            s2_data_d  = acc_sum;
            s2_ovf_d   = sticky | beat_ovf;
            s2_cnt_d   = cnt_inc;
            acc_d      = '0;
            cnt_d      = '0;
            sticky_d   = 1'b0;
            state_d    = IDLE;
          end else begin
            acc_d    = acc_sum;
            cnt_d    = cnt_inc;
            sticky_d = sticky | beat_ovf;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      acc          <= '0;
      cnt          <= '0;
      sticky       <= 1'b0;
      group_signed <= 1'b0;
      s2_valid     <= 1'b0;
      s2_data      <= '0;
      s2_ovf       <= 1'b0;
      s2_cnt       <= '0;
    end else if (advance) begin
      state        <= state_d;
      acc          <= acc_d;
      cnt          <= cnt_d;
      sticky       <= sticky_d;
      group_signed <= group_signed_d;
      s2_valid     <= s2_valid_d;
      s2_data      <= s2_data_d;
      s2_ovf       <= s2_ovf_d;
      s2_cnt       <= s2_cnt_d;
    end
  end

  // ---------------- Output register ----------------
  // On advance the pending result was either absent or just taken, so valid
  // simply follows whether a new total arrives this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_overflow <= 1'b0;
      out_count    <= '0;
    end else if (advance) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_data     <= s2_data;
        out_overflow <= s2_ovf;
        out_count    <= s2_cnt;
      end
    end
  end

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed bench for csa_accumulator: a default-width instance (14/32/8) and a
// narrow instance (8/8/2) for overflow and count-saturation corners.
module tb_csa_accumulator;

  logic clk;
  logic rst;

  // Default-width instance
  logic        m_in_valid, m_in_ready, m_in_last, m_is_signed;
  logic [13:0] m_in_sum, m_in_carry;
  logic        m_out_valid, m_out_ready, m_out_overflow;
  logic [31:0] m_out_data;
  logic [7:0]  m_out_count;

  // Narrow instance
  logic        n_in_valid, n_in_ready, n_in_last, n_is_signed;
  logic [7:0]  n_in_sum, n_in_carry;
  logic        n_out_valid, n_out_ready, n_out_overflow;
  logic [7:0]  n_out_data;
  logic [1:0]  n_out_count;

  int vectors;
  int miscompares;
  logic [31:0] exp_q[$];

  csa_accumulator #(.IN_WIDTH(14), .ACC_WIDTH(32), .CNT_WIDTH(8)) u_main (
    .clk(clk), .rst(rst),
    .in_valid(m_in_valid), .in_ready(m_in_ready),
    .in_sum(m_in_sum), .in_carry(m_in_carry),
    .in_last(m_in_last), .is_signed(m_is_signed),
    .out_valid(m_out_valid), .out_ready(m_out_ready),
    .out_data(m_out_data), .out_overflow(m_out_overflow), .out_count(m_out_count)
  );

  csa_accumulator #(.IN_WIDTH(8), .ACC_WIDTH(8), .CNT_WIDTH(2)) u_narrow (
    .clk(clk), .rst(rst),
    .in_valid(n_in_valid), .in_ready(n_in_ready),
    .in_sum(n_in_sum), .in_carry(n_in_carry),
    .in_last(n_in_last), .is_signed(n_is_signed),
    .out_valid(n_out_valid), .out_ready(n_out_ready),
    .out_data(n_out_data), .out_overflow(n_out_overflow), .out_count(n_out_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic m_drive(input logic v, input logic [13:0] s, input logic [13:0] c,
                         input logic l, input logic sg);
    m_in_valid  = v;
    m_in_sum    = s;
    m_in_carry  = c;
    m_in_last   = l;
    m_is_signed = sg;
  endtask

  task automatic m_beat(input logic [13:0] s, input logic [13:0] c,
                        input logic l, input logic sg);
    m_drive(1'b1, s, c, l, sg);
    tick();
    m_drive(1'b0, 14'h0, 14'h0, 1'b0, 1'b0);
  endtask

  task automatic n_beat(input logic [7:0] s, input logic [7:0] c,
                        input logic l, input logic sg);
    n_in_valid  = 1'b1;
    n_in_sum    = s;
    n_in_carry  = c;
    n_in_last   = l;
    n_is_signed = sg;
    tick();
    n_in_valid  = 1'b0;
    n_in_last   = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    tick();
    vectors++;
    if (m_out_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_out_valid got %b want 0", m_out_valid);
    end
    vectors++;
    if (m_out_data !== 32'h0) begin
      miscompares++; $display("FAIL reset_out_data got %h want 0", m_out_data);
    end
    vectors++;
    if (m_out_overflow !== 1'b0 || m_out_count !== 8'h0) begin
      miscompares++;
      $display("FAIL reset_ovf_cnt got %b/%0d want 0/0", m_out_overflow, m_out_count);
    end
    vectors++;
    if (n_out_valid !== 1'b0 || n_out_data !== 8'h0) begin
      miscompares++;
      $display("FAIL reset_narrow got %b/%h want 0/00", n_out_valid, n_out_data);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (m_in_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_in_ready got %b want 1", m_in_ready);
    end
  endtask

  task automatic test_unsigned_single;
    m_beat(14'h0000, 14'h000C, 1'b1, 1'b0);
    vectors++;
    if (m_out_valid !== 1'b0) begin
      miscompares++; $display("FAIL latency_k got %b want 0", m_out_valid);
    end
    tick();
    vectors++;
    if (m_out_valid !== 1'b0) begin
      miscompares++; $display("FAIL latency_k1 got %b want 0", m_out_valid);
    end
    tick();
    vectors++;
    if (m_out_valid !== 1'b1 || m_out_data !== 32'd12 || m_out_count !== 8'd1 ||
        m_out_overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL unsigned_single got v=%b d=%h c=%0d o=%b want v=1 d=0000000c c=1 o=0",
               m_out_valid, m_out_data, m_out_count, m_out_overflow);
    end
    tick();
    vectors++;
    if (m_out_valid !== 1'b0) begin
      miscompares++; $display("FAIL unsigned_drain got %b want 0", m_out_valid);
    end
    // Resolve wraps at IN_WIDTH: 0x3FFF + 3 -> 2
    m_beat(14'h3FFF, 14'h0003, 1'b1, 1'b0);
    tick(); tick();
    vectors++;
    if (m_out_valid !== 1'b1 || m_out_data !== 32'h0000_0002) begin
      miscompares++;
      $display("FAIL cpa_wrap got v=%b d=%h want v=1 d=00000002", m_out_valid, m_out_data);
    end
    // Unsigned beat with MSB set must zero-extend
    m_beat(14'h2000, 14'h0000, 1'b1, 1'b0);
    tick(); tick();
    vectors++;
    if (m_out_data !== 32'h0000_2000) begin
      miscompares++; $display("FAIL zero_extend got %h want 00002000", m_out_data);
    end
    tick();
  endtask

  task automatic test_signed_group;
    m_beat(14'h3FF0, 14'h000B, 1'b0, 1'b1);  // -5
    m_beat(14'h0003, 14'h0004, 1'b0, 1'b1);  // +7
    m_beat(14'h2000, 14'h1FF6, 1'b1, 1'b1);  // -10
    tick(); tick();
    vectors++;
    if (m_out_valid !== 1'b1 || m_out_data !== 32'hFFFF_FFF8 || m_out_count !== 8'd3 ||
        m_out_overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL signed_group got v=%b d=%h c=%0d o=%b want v=1 d=fffffff8 c=3 o=0",
               m_out_valid, m_out_data, m_out_count, m_out_overflow);
    end
    tick();
  endtask

  task automatic test_mode_mismatch;
    // Signed -1 then unsigned 0x3FFF: group is signed, so no overflow despite carry out.
    m_beat(14'h3FFF, 14'h0000, 1'b0, 1'b1);
    m_beat(14'h3FFF, 14'h0000, 1'b1, 1'b0);
    tick(); tick();
    vectors++;
    if (m_out_data !== 32'h0000_3FFE || m_out_overflow !== 1'b0 || m_out_count !== 8'd2) begin
      miscompares++;
      $display("FAIL mode_mismatch got d=%h o=%b c=%0d want d=00003ffe o=0 c=2",
               m_out_data, m_out_overflow, m_out_count);
    end
    tick();
  endtask

  task automatic test_overflow;
    n_beat(8'h60, 8'h04, 1'b0, 1'b1);  // +100
    n_beat(8'h32, 8'h32, 1'b1, 1'b1);  // +100
    tick(); tick();
    vectors++;
    if (n_out_valid !== 1'b1 || n_out_data !== 8'hC8 || n_out_overflow !== 1'b1 ||
        n_out_count !== 2'd2) begin
      miscompares++;
      $display("FAIL signed_ovf got v=%b d=%h o=%b c=%0d want v=1 d=c8 o=1 c=2",
               n_out_valid, n_out_data, n_out_overflow, n_out_count);
    end
    n_beat(8'h01, 8'h00, 1'b1, 1'b1);
    tick(); tick();
    vectors++;
    if (n_out_data !== 8'h01 || n_out_overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_cleared got d=%h o=%b want d=01 o=0", n_out_data, n_out_overflow);
    end
    n_beat(8'hC0, 8'h08, 1'b0, 1'b0);  // 200
    n_beat(8'h64, 8'h00, 1'b1, 1'b0);  // 100
    tick(); tick();
    vectors++;
    if (n_out_data !== 8'h2C || n_out_overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL unsigned_ovf got d=%h o=%b want d=2c o=1", n_out_data, n_out_overflow);
    end
    tick();
  endtask

  task automatic test_count_saturation;
    for (int i = 0; i < 5; i++) n_beat(8'h01, 8'h00, (i == 4), 1'b0);
    tick(); tick();
    vectors++;
    if (n_out_data !== 8'h05 || n_out_count !== 2'd3 || n_out_overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL count_sat got d=%h c=%0d o=%b want d=05 c=3 o=0",
               n_out_data, n_out_count, n_out_overflow);
    end
    tick();
  endtask

  task automatic test_backpressure;
    m_out_ready = 1'b0;
    m_drive(1'b1, 14'd1, 14'd0, 1'b1, 1'b0); tick();
    m_drive(1'b1, 14'd2, 14'd0, 1'b1, 1'b0); tick();
    m_drive(1'b1, 14'd3, 14'd0, 1'b1, 1'b0); tick();
    m_drive(1'b1, 14'd4, 14'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (m_in_ready !== 1'b0 || m_out_valid !== 1'b1 || m_out_data !== 32'd1) begin
        miscompares++;
        $display("FAIL stall_hold[%0d] got rdy=%b v=%b d=%h want rdy=0 v=1 d=00000001",
                 i, m_in_ready, m_out_valid, m_out_data);
      end
      tick();
    end
    m_out_ready = 1'b1;
    tick();
    m_drive(1'b0, 14'h0, 14'h0, 1'b0, 1'b0);
    for (int i = 2; i <= 4; i++) begin
      vectors++;
      if (m_out_valid !== 1'b1 || m_out_data !== 32'(i)) begin
        miscompares++;
        $display("FAIL drain[%0d] got v=%b d=%h want v=1 d=%h", i, m_out_valid, m_out_data, 32'(i));
      end
      tick();
    end
    vectors++;
    if (m_out_valid !== 1'b0) begin
      miscompares++; $display("FAIL drain_empty got %b want 0", m_out_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp;
    for (int i = 0; i < 8; i++) begin
      if (i < 6) begin
        m_drive(1'b1, 14'(10 + i), 14'h0, 1'b1, 1'b0);
        exp_q.push_back(32'(10 + i));
      end else begin
        m_drive(1'b0, 14'h0, 14'h0, 1'b0, 1'b0);
      end
      tick();
      if (i >= 2) begin
        exp = exp_q.pop_front();
        vectors++;
        if (m_out_valid !== 1'b1 || m_out_data !== exp) begin
          miscompares++;
          $display("FAIL back_to_back[%0d] got v=%b d=%h want v=1 d=%h",
                   i, m_out_valid, m_out_data, exp);
        end
      end
    end
    tick();
    vectors++;
    if (m_out_valid !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL back_to_back_end got v=%b left=%0d want v=0 left=0",
               m_out_valid, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_group;
    logic seen;
    m_beat(14'd100, 14'd0, 1'b0, 1'b0);
    m_beat(14'd200, 14'd0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (m_out_valid === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++; $display("FAIL reset_discard got out_valid=1 want 0");
    end
    m_beat(14'd5, 14'd0, 1'b0, 1'b0);
    m_beat(14'd6, 14'd0, 1'b1, 1'b0);
    tick(); tick();
    vectors++;
    if (m_out_valid !== 1'b1 || m_out_data !== 32'd11 || m_out_count !== 8'd2) begin
      miscompares++;
      $display("FAIL after_reset got v=%b d=%h c=%0d want v=1 d=0000000b c=2",
               m_out_valid, m_out_data, m_out_count);
    end
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    m_drive(1'b0, 14'h0, 14'h0, 1'b0, 1'b0);
    m_out_ready = 1'b1;
    n_in_valid  = 1'b0;
    n_in_sum    = 8'h0;
    n_in_carry  = 8'h0;
    n_in_last   = 1'b0;
    n_is_signed = 1'b0;
    n_out_ready = 1'b1;
    tick();
    test_reset();
    test_unsigned_single();
    test_signed_group();
    test_mode_mismatch();
    test_overflow();
    test_count_saturation();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_group();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/csa_accumulator.md
# csa_accumulator

Downstream stage of the 4:2 compressor tree: resolves each redundant sum/carry pair into a two's-complement value, accumulates successive beats into a wide register, and emits one result per group of beats delimited by `in_last`. It closes the dot-product datapath between the compressor tree and the result writeback, with valid/ready handshakes on both sides.

## Interface
- `IN_WIDTH`, 14, width of `in_sum` and `in_carry`; carry already shifted by upstream.
- `ACC_WIDTH`, 32, accumulator and result width; must satisfy ACC_WIDTH ≥ IN_WIDTH.
- `CNT_WIDTH`, 8, beat counter width.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  beat present.
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`.
- `in_sum`  in  IN_WIDTH  redundant sum vector.
- `in_carry`  in  IN_WIDTH  redundant carry vector.
- `in_last`  in  1  final beat of the group.
- `is_signed`  in  1  per-beat operand mode; held constant within a group by upstream.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  result consumed when `out_valid && out_ready`.
- `out_data`  out  ACC_WIDTH  group total.
- `out_overflow`  out  1  sticky overflow seen in the group.
- `out_count`  out  CNT_WIDTH  beats in the group; saturates at all-ones.

## Operation
- Global stall: `advance = !out_valid || out_ready`; `in_ready = advance`. Stage 1, stage 2 and the output register update only when `advance`.
- Stage 1 (CPA): `v = (in_sum + in_carry) mod 2^IN_WIDTH`, then extend to ACC_WIDTH. Sign-extend if `is_signed`, zero-extend otherwise. Register `v`, `in_last`, `is_signed` and `s1_valid`.
- Stage 2 uses FSM `acc_state_e`, with states IDLE (no open group) and ACCUM (partial total held).
  - IDLE + s1 beat, not last: `acc <= v`, `cnt <= 1`, latch group mode, go to ACCUM.
  - IDLE + s1 beat, last: load the output register with `v`, overflow 0, count 1. Stay in IDLE.
  - ACCUM + s1 beat, not last: `acc <= acc + v`, `cnt++` (saturating), OR overflow into sticky flag.
  - ACCUM + s1 beat, last: load the output register with `acc + v`, final sticky flag and `cnt+1`. Clear `acc`, `cnt` and sticky. Go to IDLE.
- Overflow uses the latched group mode. Signed: both addends have equal MSBs and the result MSB differs. Unsigned: carry out of bit ACC_WIDTH-1. The result wraps modulo 2^ACC_WIDTH and is never saturated.
- Mode mismatch within a group: each beat is still extended by its own flag, and overflow uses the group mode. No error is flagged.
- Output register: `out_valid` sets on a last-beat load. It clears on handshake unless a new last-beat load occurs in the same cycle; in that case it stays high with the new data.

## Timing
- Reset values: `out_valid` 0, `out_data` 0, `out_overflow` 0, `out_count` 0, `s1_valid` 0, `acc` 0, state IDLE. `in_ready` is 1 after reset.
- Latency: a last beat accepted at edge k gives `out_valid` high after edge k+2.
- Throughput: one beat per cycle while `out_ready` is 1 or no result is pending.
- While `out_valid && !out_ready`: `in_ready` 0, and all pipeline state and outputs are frozen.
- Back-to-back single-beat groups sustain one result per cycle when `out_ready` is held 1.
- Reset asserted mid-group discards the partial group and any pending result; nothing is emitted for it.

## Structure
- Shared package `ai_core_pkg`: the `acc_state_e` typedef (IDLE, ACCUM) and a width-check function asserting ACC_WIDTH ≥ IN_WIDTH.
- One sub-module, `carry_propagate_adder #(WIDTH)`, computes `a + b` with carry-out. It is used in stage 1 and reused for the accumulator add, with its carry-out feeding the overflow logic.
- Reuse the existing `sign_extender` for the IN_WIDTH→ACC_WIDTH extension.

## Test plan
- Unsigned, IN_WIDTH=4: sum=4'b0000, carry=4'b1100, last=1 → `out_data`=12, `out_count`=1, `out_overflow`=0, two cycles after acceptance.
- Signed group of 3 beats with resolved values −5, +7, −10 → `out_data`=−8 (0xFFFFFFF8), count 3, overflow 0.
- Signed, ACC_WIDTH=8, beats +100, +100, last → `out_data`=0xC8, `out_overflow`=1. The next group, a single beat of +1, gives overflow 0.
- `out_ready` held 0 with a result pending while new beats arrive → `in_ready`=0 and `out_data` stable. Releasing `out_ready` drains the result, and the queued groups follow with no loss.
- Single-beat last groups every cycle with `out_ready`=1 → one result per cycle, in order.
- `rst` pulsed after 2 beats of a 4-beat group → no output. The next group's result excludes the discarded beats.
